// File: rtl/cpu_clock_ctrl.sv
// ============================================================================
// Module  : cpu_clock_ctrl
// Brief   : Run/single-step clock-enable controller for the RISC core.
//           Optional clk_sq LED output enabled by CPU_CLOCK_CTRL_SQUARE_OUT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_clock_ctrl #(
    parameter int unsigned DIV_LIMIT       = 500,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        cpu_halt,
    output logic        cpu_en,
    output logic [1:0]  state,
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
    output logic        clk_sq,
`endif
    output logic [15:0] pulse_count
);

    localparam logic [CNT_W-1:0] c_div_limit = CNT_W'(DIV_LIMIT);
    localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]      c_cnt_max   = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    logic [CNT_W-1:0] r_presc;
    logic             w_tick;

    logic             r_run_s1;
    logic             r_run_s2;
    logic             r_step_s1;
    logic             r_step_s2;

    logic [CNT_W-1:0] r_db_cnt;
    logic             r_db_level;
    logic             w_db_accept;
    logic             r_step_req;

    state_t           r_state;
    logic             r_cpu_en;
    logic [15:0]      r_pulse_count;

    // ------------------------------------------------------------------
    // Prescaler: free-running in every state
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == c_div_limit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous board inputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run_s1  <= 1'b0;
            r_run_s2  <= 1'b0;
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
        end else begin
            r_run_s1  <= run_sw;
            r_run_s2  <= r_run_s1;
            r_step_s1 <= step_btn;
            r_step_s2 <= r_step_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
    // differing samples; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    assign w_db_accept = (r_step_s2 != r_db_level) && (r_db_cnt == c_db_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_step_req <= 1'b0;
        end else begin
            r_step_req <= w_db_accept && r_step_s2;
            if (r_step_s2 == r_db_level) begin
                r_db_cnt <= '0;
            end else if (w_db_accept) begin
                r_db_level <= r_step_s2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered enable pulse
    // ------------------------------------------------------------------
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
    logic r_clk_sq;
    assign clk_sq = r_clk_sq;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cpu_en <= 1'b0;
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
            r_clk_sq <= 1'b0;
`endif
        end else begin
            r_cpu_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_halt) begin
                        r_state <= ST_HALTED;
                    end else if (r_run_s2) begin
                        r_state <= ST_RUN;
                    end else if (r_step_req) begin
                        r_state <= ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (cpu_halt) begin
                        r_state <= ST_HALTED;
                    end else if (!r_run_s2) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        r_cpu_en <= 1'b1;
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
                        r_clk_sq <= ~r_clk_sq;
`endif
                    end
                end
                ST_STEP: begin
                    // Extra step requests and run_sw are dropped while waiting
                    if (cpu_halt) begin
                        r_state <= ST_HALTED;
                    end else if (w_tick) begin
                        r_cpu_en <= 1'b1;
                        r_state  <= ST_IDLE;
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
                        r_clk_sq <= ~r_clk_sq;
`endif
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating pulse counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pulse_count <= '0;
        end else if (r_cpu_en && (r_pulse_count != c_cnt_max)) begin
            r_pulse_count <= r_pulse_count + 16'd1;
        end
    end

    assign cpu_en      = r_cpu_en;
    assign state       = r_state;
    assign pulse_count = r_pulse_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
// ============================================================================
// Module  : tb_cpu_clock_ctrl
// Brief   : Directed self-checking bench for cpu_clock_ctrl.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_clock_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rst_n2;
    logic        run_sw;
    logic        step_btn;
    logic        cpu_halt;
    logic        cpu_en;
    logic [1:0]  state;
    logic [15:0] pulse_count;
    logic        cpu_en2;
    logic [1:0]  state2;
    logic [15:0] pulse_count2;
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
    logic        clk_sq;
    logic        clk_sq2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cpu_clock_ctrl #(.DIV_LIMIT(4), .DEBOUNCE_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn),
        .cpu_halt(cpu_halt), .cpu_en(cpu_en), .state(state),
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
        .clk_sq(clk_sq),
`endif
        .pulse_count(pulse_count)
    );

    // Long prescaler so two presses fit inside a single STEP wait
    cpu_clock_ctrl #(.DIV_LIMIT(40), .DEBOUNCE_CYCLES(3), .CNT_W(32)) dut2 (
        .clk(clk), .rst_n(rst_n2), .run_sw(1'b0), .step_btn(step_btn),
        .cpu_halt(1'b0), .cpu_en(cpu_en2), .state(state2),
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
        .clk_sq(clk_sq2),
`endif
        .pulse_count(pulse_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge for sampling/driving
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int en_cnt;
        int en_edge;
        int saw_step;
        int bad_state;
        logic exp_sq;

        rst_n    = 1'b0;
        rst_n2   = 1'b0;
        run_sw   = 1'b1;
        step_btn = 1'b0;
        cpu_halt = 1'b0;
        exp_sq   = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_en", 32'(cpu_en), 32'd0);
        chk("reset_count", 32'(pulse_count), 32'd0);
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
        chk("reset_sq", 32'(clk_sq), 32'd0);
`endif

        // Run mode: RUN after edge 3, pulses after edges 5,10,15,20
        rst_n = 1'b1;
        bad_state = 0;
        en_cnt = 0;
        for (int n = 1; n <= 21; n++) begin
            tick();
            if (state !== ((n < 3) ? 2'd0 : 2'd1)) bad_state++;
            if (cpu_en !== ((n % 5 == 0) && n <= 20)) en_cnt++;
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
            if ((n % 5 == 0) && n <= 20) exp_sq = ~exp_sq;
            chk("run_sq", 32'(clk_sq), 32'(exp_sq));
`endif
        end
        chk("run_state_seq", 32'(bad_state), 32'd0);
        chk("run_en_seq", 32'(en_cnt), 32'd0);
        chk("run_count4", 32'(pulse_count), 32'd4);

        // Halt arriving with the tick at edge 25 suppresses the pulse
        en_cnt = 0;
        repeat (3) begin
            tick();
            if (cpu_en) en_cnt++;
        end
        cpu_halt = 1'b1;
        tick();
        if (cpu_en) en_cnt++;
        chk("halt_state", 32'(state), 32'd3);
        cpu_halt = 1'b0;
        run_sw   = 1'b0;
        repeat (4) begin tick(); if (cpu_en) en_cnt++; end
        run_sw   = 1'b1;
        step_btn = 1'b1;
        repeat (8) begin tick(); if (cpu_en) en_cnt++; end
        step_btn = 1'b0;
        repeat (8) begin tick(); if (cpu_en) en_cnt++; end
        chk("halt_no_pulse", 32'(en_cnt), 32'd0);
        chk("halt_sticky", 32'(state), 32'd3);
        chk("halt_count", 32'(pulse_count), 32'd4);

        rst_n  = 1'b0;
        run_sw = 1'b0;
        tick();
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_count", 32'(pulse_count), 32'd0);
        tick();

        // Bounced press: accepted at edge 9, STEP at 10, pulse at edge 15
        rst_n = 1'b1;
        en_cnt = 0;
        en_edge = 0;
        saw_step = 0;
        for (int i = 0; i < 25; i++) begin
            step_btn = (i == 0 || i == 2 || (i >= 4 && i < 14));
            tick();
            if (cpu_en) begin en_cnt++; en_edge = i + 1; end
            if (state == 2'd2) saw_step = 1;
        end
        step_btn = 1'b0;
        chk("bounce_pulses", 32'(en_cnt), 32'd1);
        chk("bounce_edge", 32'(en_edge), 32'd15);
        chk("bounce_saw_step", 32'(saw_step), 32'd1);
        chk("bounce_state", 32'(state), 32'd0);
        chk("bounce_count", 32'(pulse_count), 32'd1);

        // Two-sample glitch never reaches the debounce threshold
        en_cnt = 0;
        bad_state = 0;
        for (int i = 0; i < 15; i++) begin
            step_btn = (i < 2);
            tick();
            if (cpu_en) en_cnt++;
            if (state != 2'd0) bad_state++;
        end
        chk("glitch_pulses", 32'(en_cnt), 32'd0);
        chk("glitch_state", 32'(bad_state), 32'd0);

        // Saturation from a preloaded count
        run_sw = 1'b1;
        repeat (4) tick();
        chk("sat_run_state", 32'(state), 32'd1);
        force dut.r_pulse_count = 16'hFFFD;
        tick();
        release dut.r_pulse_count;
        en_cnt = 0;
        repeat (17) begin tick(); if (cpu_en) en_cnt++; end
        chk("sat_min_pulses", 32'(en_cnt >= 3), 32'd1);
        chk("sat_count", 32'(pulse_count), 32'h0000FFFF);

        // Dropping run_sw returns to IDLE after sync latency
        run_sw = 1'b0;
        repeat (3) tick();
        chk("runoff_state", 32'(state), 32'd0);

        // Second press during the STEP wait is not queued (dut2)
        rst_n2 = 1'b1;
        en_cnt = 0;
        en_edge = 0;
        for (int i = 0; i < 90; i++) begin
            step_btn = (i < 6) || (i >= 12 && i < 18);
            tick();
            if (cpu_en2) begin en_cnt++; en_edge = i + 1; end
            if (i == 25) chk("dbl_wait_state", 32'(state2), 32'd2);
        end
        chk("dbl_pulses", 32'(en_cnt), 32'd1);
        chk("dbl_edge", 32'(en_edge), 32'd41);
        chk("dbl_state", 32'(state2), 32'd0);
        chk("dbl_count", 32'(pulse_count2), 32'd1);
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
        chk("dbl_sq", 32'(clk_sq2), 32'd1);
`endif

        // Reset while waiting in STEP
        for (int i = 0; i < 8; i++) begin
            step_btn = (i < 6);
            tick();
        end
        chk("midstep_pre", 32'(state2), 32'd2);
        rst_n2 = 1'b0;
        tick();
        chk("midstep_en", 32'(cpu_en2), 32'd0);
        chk("midstep_state", 32'(state2), 32'd0);
        chk("midstep_count", 32'(pulse_count2), 32'd0);
`ifdef CPU_CLOCK_CTRL_SQUARE_OUT_EN
        chk("midstep_sq", 32'(clk_sq2), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Run/single-step controller for the RISC core on the FPGA board.
- Sits downstream of the board clock divider, at the same rate. Produces a one-cycle clock-enable pulse for the CPU at a divided rate (run mode) or one pulse per debounced button press (step mode).
- Stops the CPU when the core asserts halt.
- All logic is on the board clock; the CPU uses cpu_en as a synchronous enable.

Parameters:
- DIV_LIMIT, 500, prescaler terminal count; one tick every DIV_LIMIT+1 clk cycles.
- DEBOUNCE_CYCLES, 1000, consecutive stable synchronized samples needed to accept a step_btn level change (>=1).
- CNT_W, 32, prescaler and debounce counter width.

Ports:
- clk  input  1  board clock
- rst_n  input  1  synchronous active-low reset
- run_sw  input  1  run switch, asynchronous to clk
- step_btn  input  1  raw step pushbutton, asynchronous, bouncy
- cpu_halt  input  1  halt flag from the CPU, synchronous to clk, level
- cpu_en  output  1  one-clk-wide CPU advance pulse
- state  output  2  FSM state: 0 IDLE, 1 RUN, 2 STEP, 3 HALTED
- pulse_count  output  16  number of cpu_en pulses issued, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-low (ports clk and rst_n).
- Reset (rst_n=0 at a clk edge) values:
  - cpu_en=0, state=IDLE, pulse_count=0, prescaler=0.
  - Sync flops 0, debounced level 0, debounce counter 0.
  - Reset mid-operation aborts any pending step or run with no cpu_en pulse in the reset cycle.
- Prescaler:
  - Free-running 0..DIV_LIMIT in every state.
  - At DIV_LIMIT it wraps to 0 and asserts internal tick for that cycle.
  - First tick occurs DIV_LIMIT cycles after reset release.
- Synchronizers: run_sw and step_btn each pass through 2 flops. cpu_halt is used directly.
- Debounce:
  - If the synchronized step sample equals the debounced level, the counter is cleared to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 with the sample still differing, the debounced level takes the sample value and the counter clears.
  - step_req is a registered one-cycle pulse on a 0->1 debounced transition.
- FSM, evaluated each clk. Priority: cpu_halt > run_sw > step_req.
  - IDLE: cpu_halt -> HALTED; else run_sw_s=1 -> RUN; else step_req -> STEP.
  - RUN: cpu_halt -> HALTED, no pulse that cycle even if tick. Else run_sw_s=0 -> IDLE, no pulse. Else cpu_en=tick.
  - STEP: cpu_halt -> HALTED, no pulse. Else on tick: cpu_en=1 for that cycle, then -> IDLE. While waiting, further step_req is ignored (not queued) and run_sw is ignored.
  - HALTED: cpu_en=0. Exit only via reset. step_req and run_sw are ignored.
- cpu_en is registered: asserted in the cycle after the FSM decision and never more than 1 cycle wide.
- pulse_count increments on every cpu_en=1 and saturates at 16'hFFFF (no wrap).
- state output reflects the registered FSM state.

Optional Feature:
- Macro: CPU_CLOCK_CTRL_SQUARE_OUT_EN.
- With the macro defined:
  - Extra output port clk_sq (1 bit, reset 0) toggles in the same cycle that cpu_en is asserted.
  - This gives a board-LED-visible square wave at half the CPU advance rate.
  - It holds its level when no pulses are issued.
- Without the macro: the clk_sq port and its flop are absent. All other behaviour is identical.

Test Plan (DIV_LIMIT=4, DEBOUNCE_CYCLES=3):
- Reset, run_sw=1 held -> state=RUN after sync latency; cpu_en pulses exactly every 5 clk, each 1 cycle wide; pulse_count=4 after 4 pulses.
- In RUN, cpu_halt=1 in the same cycle as a tick -> no cpu_en that tick; state=HALTED; no further pulses after run_sw toggles or step presses; only rst_n=0 returns to IDLE with pulse_count=0.
- IDLE, step_btn bounced 1,0,1,0 on alternate cycles then held 1 for 10 cycles -> exactly one step_req; exactly one cpu_en on the next tick; state returns to IDLE; pulse_count=1.
- step_btn high for only 2 synchronized cycles -> no step_req, no cpu_en.
- Second debounced press while in STEP waiting for tick -> still exactly one cpu_en.
- Force pulse_count near 16'hFFFE, run for 3 ticks -> pulse_count holds at 16'hFFFF.
- With CPU_CLOCK_CTRL_SQUARE_OUT_EN defined -> clk_sq toggles on every cpu_en, reset value 0.
- rst_n=0 asserted mid-STEP -> cpu_en=0, state=IDLE, pulse_count=0 next cycle.
